// File: rtl/uart_tx_pkg.sv
// Shared encodings for the UART transmit frame controller.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic EVEN      = 1'b0;
    localparam logic ODD       = 1'b1;
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/parity_calc.sv
// Parity bit for a latched byte: XOR-reduce of the data, inverted for odd parity.
module parity_calc
    import uart_tx_pkg::*;
#(
    parameter int unsigned Data_Width = 8
) (
    input  logic [Data_Width-1:0] data_i,
    input  logic                  par_typ_i,
    output logic                  parity_o
);

    assign parity_o = (^data_i) ^ (par_typ_i == ODD);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: latches a byte, sequences the serializer and
// drives the registered serial line (start, data LSB first, optional parity, stop).
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int unsigned Data_Width = 8
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  Data_Valid,
    input  logic [Data_Width-1:0] P_Data,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  Ser_Data,
    input  logic                  Ser_Done,
    output logic [Data_Width-1:0] P_Data_Out,
    output logic                  Ser_En,
    output logic                  TX_OUT,
    output logic                  Busy
);

    tx_state_e             state_q, state_d;
    logic [Data_Width-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  accept;
    logic                  parity_bit;

    parity_calc #(
        .Data_Width(Data_Width)
    ) u_parity_calc (
        .data_i   (data_q),
        .par_typ_i(par_typ_q),
        .parity_o (parity_bit)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        tx_d      = LINE_IDLE;
        accept    = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d = LINE_IDLE;
                if (Data_Valid) begin
                    accept  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                tx_d    = START_BIT;
                state_d = DATA;
            end
            DATA: begin
                tx_d = Ser_Data;
                if (Ser_Done) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                tx_d    = parity_bit;
                state_d = STOP;
            end
            STOP: begin
                tx_d = LINE_IDLE;
                // A request during the stop cycle chains straight into the next start bit.
                if (Data_Valid) begin
                    accept  = 1'b1;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            data_d    = P_Data;
            par_en_d  = PAR_EN;
            par_typ_d = PAR_TYP;
        end

        // Held one extra cycle after STOP so Busy spans the registered stop bit.
        busy_d = (state_d != IDLE) || (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= EVEN;
            tx_q      <= LINE_IDLE;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign P_Data_Out = data_q;
    assign Ser_En     = (state_q == DATA);
    assign TX_OUT     = tx_q;
    assign Busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: vector table of frames, scoreboarded line monitor,
// and directed sequences for back-to-back, ignored inputs and mid-frame reset.
module tb_uart_tx_ctrl;

    logic       clk;
    logic       RST;
    logic       Data_Valid;
    logic [7:0] P_Data;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       Ser_Data;
    logic       Ser_Done;
    logic [7:0] P_Data_Out;
    logic       Ser_En;
    logic       TX_OUT;
    logic       Busy;

    logic       spur_done;
    logic [2:0] ser_cnt;

    int checks   = 0;
    int failures = 0;
    int frames_done = 0;

    typedef struct {
        logic [10:0] bits;
        int          len;
        string       name;
    } frame_t;

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_typ;
        logic       par_bit;
        string      name;
    } vec_t;

    frame_t exp_q[$];
    vec_t   vecs[7];

    uart_tx_ctrl #(
        .Data_Width(8)
    ) dut (
        .clk       (clk),
        .RST       (RST),
        .Data_Valid(Data_Valid),
        .P_Data    (P_Data),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .Ser_Data  (Ser_Data),
        .Ser_Done  (Ser_Done),
        .P_Data_Out(P_Data_Out),
        .Ser_En    (Ser_En),
        .TX_OUT    (TX_OUT),
        .Busy      (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serializer model: shifts the presented byte LSB first, done on the 8th enabled cycle.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            ser_cnt <= 3'd0;
        end else if (Ser_En) begin
            ser_cnt <= ser_cnt + 3'd1;
        end else begin
            ser_cnt <= 3'd0;
        end
    end

    assign Ser_Data = P_Data_Out[ser_cnt];
    assign Ser_Done = (Ser_En && (ser_cnt == 3'd7)) || spur_done;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic frame_t mk(input logic [7:0] d, input logic pe, input logic pb,
                                  input string nm);
        frame_t f;
        f.bits      = '1;
        f.bits[0]   = 1'b0;
        f.bits[8:1] = d;
        if (pe) begin
            f.bits[9]  = pb;
            f.bits[10] = 1'b1;
            f.len      = 11;
        end else begin
            f.bits[9] = 1'b1;
            f.len     = 10;
        end
        f.name = nm;
        return f;
    endfunction

    // Line monitor: a falling line starts a frame, each cycle compared against the scoreboard.
    initial begin : monitor
        frame_t cur;
        int     idx;
        bit     active;
        active = 1'b0;
        idx    = 0;
        forever begin
            @(negedge clk);
            if (!RST) begin
                active = 1'b0;
            end else begin
                if (!active && TX_OUT == 1'b0) begin
                    if (exp_q.size() == 0) begin
                        chk1("unexpected_start", TX_OUT, 1'b1);
                    end else begin
                        cur    = exp_q.pop_front();
                        idx    = 0;
                        active = 1'b1;
                    end
                end
                if (active) begin
                    chk1($sformatf("%s_bit%0d", cur.name, idx), TX_OUT, cur.bits[idx]);
                    chk1($sformatf("%s_busy%0d", cur.name, idx), Busy, 1'b1);
                    idx++;
                    if (idx == cur.len) begin
                        active = 1'b0;
                        frames_done++;
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic pb,
                        input string nm);
        @(negedge clk);
        Data_Valid = 1'b1;
        P_Data     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        exp_q.push_back(mk(d, pe, pb, nm));
        @(negedge clk);
        // Scramble inputs after acceptance; the latched copies must be used.
        Data_Valid = 1'b0;
        P_Data     = ~d;
        PAR_EN     = ~pe;
        PAR_TYP    = ~pt;
        #1;
        chk1({nm, "_busy_rise"}, Busy, 1'b1);
        chk1({nm, "_pre_start"}, TX_OUT, 1'b1);
    endtask

    task automatic wait_frames(input int tgt, input bit busy_chk, input string nm);
        int n;
        n = 0;
        while (frames_done < tgt && n < 60) begin
            @(negedge clk);
            #1;
            if (busy_chk) chk1({nm, "_busy_held"}, Busy, 1'b1);
            n++;
        end
        chkn({nm, "_frame_count"}, frames_done, tgt);
    endtask

    task automatic wait_ser(input logic val, input string nm);
        int n;
        n = 0;
        while (Ser_En !== val && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk1({nm, "_ser_en"}, Ser_En, val);
    endtask

    task automatic check_idle_after(input string nm);
        @(posedge clk);
        #1;
        chk1({nm, "_busy_fall"}, Busy, 1'b0);
        chk1({nm, "_line_idle"}, TX_OUT, 1'b1);
        chk1({nm, "_ser_en_low"}, Ser_En, 1'b0);
    endtask

    initial begin : stimulus
        int target;
        target     = 0;
        RST        = 1'b0;
        Data_Valid = 1'b0;
        P_Data     = 8'h00;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        spur_done  = 1'b0;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, "a5_nopar"};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b1, "p07_even"};
        vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b0, "p07_odd"};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b0, "p00_even"};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1, "p00_odd"};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, "pff_odd"};
        vecs[6] = '{8'h80, 1'b0, 1'b1, 1'b0, "b80_nopar"};

        repeat (3) @(negedge clk);
        #1;
        chk1("reset_tx", TX_OUT, 1'b1);
        chk1("reset_busy", Busy, 1'b0);
        chk1("reset_ser_en", Ser_En, 1'b0);
        chkn("reset_p_data_out", int'(P_Data_Out), 0);
        @(negedge clk);
        RST = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #1;
            chk1("idle_tx", TX_OUT, 1'b1);
            chk1("idle_busy", Busy, 1'b0);
            chk1("idle_ser_en", Ser_En, 1'b0);
        end

        for (int i = 0; i < 7; i++) begin
            send(vecs[i].data, vecs[i].par_en, vecs[i].par_typ, vecs[i].par_bit, vecs[i].name);
            target++;
            wait_frames(target, 1'b0, vecs[i].name);
            check_idle_after(vecs[i].name);
        end

        // Back-to-back: request 0x3C during the stop cycle of a 0xFF frame.
        send(8'hFF, 1'b0, 1'b0, 1'b0, "b2b_ff");
        wait_ser(1'b1, "b2b_data");
        wait_ser(1'b0, "b2b_stop");
        Data_Valid = 1'b1;
        P_Data     = 8'h3C;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b0;
        exp_q.push_back(mk(8'h3C, 1'b1, 1'b0, "b2b_3c"));
        @(negedge clk);
        Data_Valid = 1'b0;
        target++;
        wait_frames(target, 1'b1, "b2b_first");
        @(negedge clk);
        #1;
        chk1("b2b_start_follows_stop", TX_OUT, 1'b0);
        chk1("b2b_busy_between", Busy, 1'b1);
        target++;
        wait_frames(target, 1'b1, "b2b_second");
        check_idle_after("b2b");

        // Data_Valid during DATA must not alter or queue a frame.
        send(8'hA5, 1'b1, 1'b1, 1'b1, "ign_a5");
        wait_ser(1'b1, "ign_data");
        @(negedge clk);
        Data_Valid = 1'b1;
        P_Data     = 8'h55;
        @(negedge clk);
        Data_Valid = 1'b0;
        target++;
        wait_frames(target, 1'b0, "ign");
        check_idle_after("ign");
        repeat (12) @(negedge clk);
        #1;
        chk1("ign_no_queued_busy", Busy, 1'b0);
        chkn("ign_frames_total", frames_done, target);

        // Spurious Ser_Done while idle.
        @(negedge clk);
        spur_done = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk1("spur_busy", Busy, 1'b0);
            chk1("spur_ser_en", Ser_En, 1'b0);
            chk1("spur_tx", TX_OUT, 1'b1);
        end
        spur_done = 1'b0;
        send(8'h3C, 1'b0, 1'b0, 1'b0, "post_spur");
        target++;
        wait_frames(target, 1'b0, "post_spur");
        check_idle_after("post_spur");

        // Reset asserted while the 4th data bit is on the line.
        send(8'hA5, 1'b0, 1'b0, 1'b0, "rst_a5");
        wait_ser(1'b1, "rst_data");
        repeat (4) @(negedge clk);
        #2;
        RST = 1'b0;
        #1;
        chk1("rst_mid_tx", TX_OUT, 1'b1);
        chk1("rst_mid_busy", Busy, 1'b0);
        chk1("rst_mid_ser_en", Ser_En, 1'b0);
        repeat (2) @(negedge clk);
        RST = 1'b1;
        #1;
        chkn("rst_aborted_count", frames_done, target);
        send(8'h07, 1'b1, 1'b0, 1'b1, "post_rst");
        target++;
        wait_frames(target, 1'b0, "post_rst");
        check_idle_after("post_rst");
        chkn("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
